// File: rtl/pulse_width_encoder.sv
// Intensity/phase -> PWM rise/fall tick encoder with a CPU-writable pulse-width table.
// Optional bus readback of the table via PULSE_WIDTH_ENCODER_READBACK_EN.
module pulse_width_encoder #(
  parameter int DEPTH            = 249,
  parameter int TABLE_ADDR_WIDTH = 15
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        DIN_VALID,
  input  logic [15:0]                 INTENSITY_IN,
  input  logic [7:0]                  PHASE_IN,
  input  logic                        TABLE_WE,
  input  logic [TABLE_ADDR_WIDTH-1:0] TABLE_ADDR,
  input  logic [8:0]                  TABLE_WDATA,
  output logic [8:0]                  TABLE_RDATA,
  output logic [8:0]                  RISE,
  output logic [8:0]                  FALL,
  output logic [7:0]                  IDX,
  output logic                        DOUT_VALID,
  output logic                        FRAME_DONE
);

  localparam int STAGES = 4;
  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  // ---------------- index state machine ----------------
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] idx_cur;
  logic       idx_last;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_cur  = (state_q == IDLE) ? 8'd0 : cnt_q;
    idx_last = (idx_cur == LAST_IDX);
    if (DIN_VALID) begin
      if (idx_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = STREAM;
        cnt_d   = idx_cur + 8'd1;
      end
    end
  end

  // ---------------- pulse-width table ----------------
  logic [8:0] mem [2**TABLE_ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (TABLE_WE) mem[TABLE_ADDR] <= TABLE_WDATA;
  end

`ifdef PULSE_WIDTH_ENCODER_READBACK_EN
  logic [8:0] rdata_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rdata_q <= '0;
    else        rdata_q <= mem[TABLE_ADDR];
  end
  assign TABLE_RDATA = rdata_q;
`else
  assign TABLE_RDATA = '0;
`endif

  if (TABLE_ADDR_WIDTH < 16) begin : g_lsb
    logic unused_lsbs;
    assign unused_lsbs = ^INTENSITY_IN[15-TABLE_ADDR_WIDTH:0];
  end

  // ---------------- datapath ----------------
  // s0 input capture, s1 synchronous table read (address from s0),
  // s2 clamp + half widths, s3 edge outputs.
  logic [STAGES-1:0]           vld_pipe_q;
  logic [TABLE_ADDR_WIDTH-1:0] s0_addr_q;
  logic [7:0]                  s0_ph_q, s1_ph_q;
  logic [7:0]                  s0_idx_q, s1_idx_q, s2_idx_q;
  logic                        s0_last_q, s1_last_q, s2_last_q;
  logic [8:0]                  s1_pw_q;
  logic [8:0]                  s2_ph_q;
  logic [7:0]                  s2_lo_q, s2_hi_q;
  logic [8:0]                  pw_clamp, pw_p1;
  logic [8:0]                  rise_q, fall_q;
  logic [7:0]                  idx_q;
  logic                        done_q;

  // Read-first: the write above lands in the same edge, so old data is seen.
  always_ff @(posedge CLK) begin
    s1_pw_q <= mem[s0_addr_q];
  end

  assign pw_clamp = (s1_pw_q > 9'd256) ? 9'd256 : s1_pw_q;
  assign pw_p1    = pw_clamp + 9'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe_q <= '0;
      s0_addr_q  <= '0;
      s0_ph_q    <= '0;
      s0_idx_q   <= '0;
      s0_last_q  <= 1'b0;
      s1_ph_q    <= '0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_ph_q    <= '0;
      s2_lo_q    <= '0;
      s2_hi_q    <= '0;
      s2_idx_q   <= '0;
      s2_last_q  <= 1'b0;
      rise_q     <= '0;
      fall_q     <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-2:0], DIN_VALID};
      s0_addr_q  <= INTENSITY_IN[15 -: TABLE_ADDR_WIDTH];
      s0_ph_q    <= PHASE_IN;
      s0_idx_q   <= idx_cur;
      s0_last_q  <= idx_last;
      s1_ph_q    <= s0_ph_q;
      s1_idx_q   <= s0_idx_q;
      s1_last_q  <= s0_last_q;
      s2_ph_q    <= {s1_ph_q, 1'b0};
      s2_lo_q    <= pw_clamp[8:1];
      s2_hi_q    <= pw_p1[8:1];
      s2_idx_q   <= s1_idx_q;
      s2_last_q  <= s1_last_q;
      done_q     <= vld_pipe_q[2] & s2_last_q;
      // Edge outputs hold between valid samples; 9-bit math wraps mod 512.
      if (vld_pipe_q[2]) begin
        rise_q <= s2_ph_q - {1'b0, s2_lo_q};
        fall_q <= s2_ph_q + {1'b0, s2_hi_q};
        idx_q  <= s2_idx_q;
      end
    end
  end

  assign RISE       = rise_q;
  assign FALL       = fall_q;
  assign IDX        = idx_q;
  assign DOUT_VALID = vld_pipe_q[STAGES-1];
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_pulse_width_encoder.sv
// Directed self-checking bench for pulse_width_encoder: latency, arithmetic, wrap,
// clamp, read-first collision, frame indexing, mid-frame reset, optional readback.
module tb_pulse_width_encoder;

  logic        CLK;
  logic        RST_N;
  logic        DIN_VALID;
  logic [15:0] INTENSITY_IN;
  logic [7:0]  PHASE_IN;
  logic        TABLE_WE;
  logic [14:0] TABLE_ADDR;
  logic [8:0]  TABLE_WDATA;
  logic [8:0]  TABLE_RDATA;
  logic [8:0]  RISE;
  logic [8:0]  FALL;
  logic [7:0]  IDX;
  logic        DOUT_VALID;
  logic        FRAME_DONE;

  int n_tests = 0;
  int n_fail  = 0;
  int nidx    = 0;

  pulse_width_encoder #(.DEPTH(249), .TABLE_ADDR_WIDTH(15)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN_VALID(DIN_VALID), .INTENSITY_IN(INTENSITY_IN),
    .PHASE_IN(PHASE_IN), .TABLE_WE(TABLE_WE), .TABLE_ADDR(TABLE_ADDR),
    .TABLE_WDATA(TABLE_WDATA), .TABLE_RDATA(TABLE_RDATA), .RISE(RISE), .FALL(FALL),
    .IDX(IDX), .DOUT_VALID(DOUT_VALID), .FRAME_DONE(FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    @(negedge CLK);
    TABLE_WE = 1'b1; TABLE_ADDR = 15'(addr); TABLE_WDATA = 9'(data);
    @(negedge CLK);
    TABLE_WE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; DIN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    nidx = 0;
  endtask

  // Single isolated sample: checks latency, values and hold-after-valid.
  task automatic one(input string tag, input int inten, input int ph,
                     input int er, input int ef);
    @(negedge CLK);
    DIN_VALID = 1'b1; INTENSITY_IN = 16'(inten); PHASE_IN = 8'(ph);
    @(negedge CLK);
    DIN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk({tag, "_early"}, DOUT_VALID, 0);
    @(negedge CLK);
    chk({tag, "_vld"}, DOUT_VALID, 1);
    chk({tag, "_rise"}, RISE, er);
    chk({tag, "_fall"}, FALL, ef);
    chk({tag, "_idx"}, IDX, nidx);
    nidx = (nidx + 1) % 249;
    @(negedge CLK);
    chk({tag, "_gap"}, DOUT_VALID, 0);
    chk({tag, "_hold"}, RISE, er);
  endtask

  initial begin
    int nv;
    RST_N = 1'b0; DIN_VALID = 1'b0; INTENSITY_IN = '0; PHASE_IN = '0;
    TABLE_WE = 1'b0; TABLE_ADDR = '0; TABLE_WDATA = '0;
    repeat (3) @(negedge CLK);
    chk("rst_vld",   DOUT_VALID, 0);
    chk("rst_rise",  RISE, 0);
    chk("rst_fall",  FALL, 0);
    chk("rst_idx",   IDX, 0);
    chk("rst_done",  FRAME_DONE, 0);
    chk("rst_rdata", TABLE_RDATA, 0);
    RST_N = 1'b1;

    // pw/phase arithmetic: ph = 2*PHASE, RISE = ph - pw/2, FALL = ph + ceil(pw/2)
    wr(16'h0800, 100); one("pw100",   16'h1000, 8'h10, 494, 82);
    wr(16'h0800, 101); one("pw101",   16'h1000, 8'h10, 494, 83);
    wr(16'h0800, 300); one("clamp300", 16'h1000, 8'h00, 384, 128);
    wr(16'h0800, 257); one("clamp257", 16'h1000, 8'h80, 128, 384);
    wr(16'h0010, 0);   one("pw0",     16'h0020, 8'hFF, 510, 510);
    wr(16'h0800, 100); one("wrap",    16'h1000, 8'hF0, 430, 18);

    // Table write to the address being read in the same edge: old data (100) wins.
    @(negedge CLK);
    DIN_VALID = 1'b1; INTENSITY_IN = 16'h1000; PHASE_IN = 8'h10;
    @(negedge CLK);
    DIN_VALID = 1'b0; TABLE_WE = 1'b1; TABLE_ADDR = 15'h0800; TABLE_WDATA = 9'd200;
    @(negedge CLK);
    TABLE_WE = 1'b0;
    repeat (2) @(negedge CLK);
    chk("col_vld",  DOUT_VALID, 1);
    chk("col_rise", RISE, 494);
    chk("col_fall", FALL, 82);
    nidx = (nidx + 1) % 249;
    one("col_new", 16'h1000, 8'h10, 444, 132);

    // Full frame plus one, back to back.
    wr(16'h0800, 100);
    do_reset();
    for (int t = 0; t < 254; t++) begin
      @(negedge CLK);
      if (t >= 4) begin
        int k;
        k = t - 4;
        chk("str_vld",  DOUT_VALID, 1);
        chk("str_idx",  IDX, k % 249);
        chk("str_done", FRAME_DONE, ((k % 249) == 248) ? 1 : 0);
        chk("str_rise", RISE, (2 * (k % 256) - 50) & 511);
        chk("str_fall", FALL, (2 * (k % 256) + 50) & 511);
      end
      if (t < 250) begin
        DIN_VALID = 1'b1; INTENSITY_IN = 16'h1000; PHASE_IN = 8'(t);
      end else begin
        DIN_VALID = 1'b0;
      end
    end
    @(negedge CLK);
    chk("str_end_vld",  DOUT_VALID, 0);
    chk("str_end_done", FRAME_DONE, 0);

    // Reset in the middle of a frame with samples still in the pipe.
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      DIN_VALID = 1'b1; INTENSITY_IN = 16'h1000; PHASE_IN = 8'h10;
    end
    @(negedge CLK);
    DIN_VALID = 1'b0; RST_N = 1'b0;
    #1;
    chk("mid_rst_vld", DOUT_VALID, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    nidx = 0;
    nv = 0;
    repeat (8) begin
      @(negedge CLK);
      if (DOUT_VALID) nv++;
    end
    chk("mid_rst_flush", nv, 0);
    one("mid_rst_new", 16'h1000, 8'h10, 494, 82);

`ifdef PULSE_WIDTH_ENCODER_READBACK_EN
    wr(5, 9'h123);
    @(negedge CLK);
    chk("rb_read", TABLE_RDATA, 9'h123);
    TABLE_WE = 1'b1; TABLE_WDATA = 9'h0AA;
    @(negedge CLK);
    TABLE_WE = 1'b0;
    chk("rb_old", TABLE_RDATA, 9'h123);
    @(negedge CLK);
    chk("rb_new", TABLE_RDATA, 9'h0AA);
`else
    wr(5, 9'h123);
    @(negedge CLK);
    chk("rb_off", TABLE_RDATA, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
